// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control sequencer for the single-issue core
// Ports:
//   clk           rising-edge clock
//   rstn          synchronous active-low reset
//   instruction   current fetched instruction from the datapath
//   ex_no_stay    memcpy counter done-and-enabled flag (only used in MC_STORE)
//   ctrl_signals  packed datapath control word (combinational, zero latency)
//   busy          memcpy in progress
//   halted        ECALL/EBREAK reached, core frozen
//   illegal       unsupported opcode reached, core frozen
//   retired       saturating count of completed instructions

`ifndef CONTROLS_SVH
`define CONTROLS_SVH
`define ALU_ADD    4'd0
`define ALU_SUB    4'd1
`define ALU_SLL    4'd2
`define ALU_SLT    4'd3
`define ALU_SLTU   4'd4
`define ALU_XOR    4'd5
`define ALU_SRL    4'd6
`define ALU_SRA    4'd7
`define ALU_OR     4'd8
`define ALU_AND    4'd9
`define ALU_PASS_B 4'd10
`define LS_BYTE    2'd0
`define LS_HALF    2'd1
`define LS_WORD    2'd2
`define BR_NONE    3'd0
`define BR_BEQ     3'd1
`define BR_BNE     3'd2
`define BR_BLT     3'd3
`define BR_BGE     3'd4
`define BR_BLTU    3'd5
`define BR_BGEU    3'd6
// Three bits cannot hold none + six branches + two jumps; both jumps share
// one code and the datapath picks the target base through alu_a_sel.
`define BR_JAL     3'd7
`define BR_JALR    3'd7
`endif

module control_sequencer (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instruction,
  input  logic        ex_no_stay,
  output logic [20:0] ctrl_signals,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_MEMCPY = 7'b0001011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0]  WSRC_ALU = 2'd0;
  localparam logic [1:0]  WSRC_MEM = 2'd1;
  localparam logic [1:0]  WSRC_PC  = 2'd2;
  localparam logic [20:0] CTRL_STAY = 21'h000008;

  typedef enum logic [2:0] {BOOT, RUN, MC_LOAD, MC_STORE, HALT, TRAP} state_t;

  state_t state, state_next;
  logic   retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_instr_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign f7b5   = instruction[30];
  assign unused_instr_bits = &{1'b0, instruction[31], instruction[29:15], instruction[11:7]};

  logic       write_en, alu_b_sel, alu_a_sel, mem_write, mem_read, load_unsigned;
  logic       stay, memcpy_store, counter_en, counter_sel;
  logic [3:0] alu_sel;
  logic [1:0] ls_type, write_src_sel;
  logic [2:0] branch_type;
  logic [20:0] ctrl_word;

  // sub_en lets funct7[5] pick SUB (R-type only); sra_en lets it pick SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub_en,
                                        input logic sra_en);
    case (f3)
      3'b000:  alu_op = sub_en ? `ALU_SUB : `ALU_ADD;
      3'b001:  alu_op = `ALU_SLL;
      3'b010:  alu_op = `ALU_SLT;
      3'b011:  alu_op = `ALU_SLTU;
      3'b100:  alu_op = `ALU_XOR;
      3'b101:  alu_op = sra_en ? `ALU_SRA : `ALU_SRL;
      3'b110:  alu_op = `ALU_OR;
      default: alu_op = `ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= BOOT;
      retired <= 32'd0;
    end else begin
      state <= state_next;
      if (retire && (retired != 32'hFFFF_FFFF))
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    write_en      = 1'b0;
    alu_sel       = `ALU_ADD;
    alu_b_sel     = 1'b0;
    alu_a_sel     = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    ls_type       = `LS_BYTE;
    load_unsigned = 1'b0;
    write_src_sel = WSRC_ALU;
    branch_type   = `BR_NONE;
    stay          = 1'b0;
    memcpy_store  = 1'b0;
    counter_en    = 1'b0;
    counter_sel   = 1'b0;
    state_next    = state;
    retire        = 1'b0;

    case (state)
      BOOT: begin
        stay       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        retire = 1'b1;
        case (opcode)
          OP_R: begin
            write_en = 1'b1;
            alu_sel  = alu_op(funct3, f7b5, f7b5);
          end
          OP_I: begin
            write_en  = 1'b1;
            alu_b_sel = 1'b1;
            alu_sel   = alu_op(funct3, 1'b0, f7b5);
          end
          OP_LOAD: begin
            write_en      = 1'b1;
            alu_b_sel     = 1'b1;
            mem_read      = 1'b1;
            ls_type       = funct3[1:0];
            load_unsigned = funct3[2];
            write_src_sel = WSRC_MEM;
          end
          OP_STORE: begin
            alu_b_sel = 1'b1;
            mem_write = 1'b1;
            ls_type   = funct3[1:0];
          end
          OP_BRANCH: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            case (funct3)
              3'b000:  branch_type = `BR_BEQ;
              3'b001:  branch_type = `BR_BNE;
              3'b100:  branch_type = `BR_BLT;
              3'b101:  branch_type = `BR_BGE;
              3'b110:  branch_type = `BR_BLTU;
              3'b111:  branch_type = `BR_BGEU;
              default: branch_type = `BR_NONE;
            endcase
          end
          OP_JAL: begin
            write_en      = 1'b1;
            alu_a_sel     = 1'b1;
            write_src_sel = WSRC_PC;
            branch_type   = `BR_JAL;
          end
          OP_JALR: begin
            write_en      = 1'b1;
            write_src_sel = WSRC_PC;
            branch_type   = `BR_JALR;
          end
          OP_LUI: begin
            write_en  = 1'b1;
            alu_b_sel = 1'b1;
            alu_sel   = `ALU_PASS_B;
          end
          OP_AUIPC: begin
            write_en  = 1'b1;
            alu_b_sel = 1'b1;
            alu_a_sel = 1'b1;
          end
          OP_MEMCPY: begin
            // memcpy retires only when its last store completes
            retire     = 1'b0;
            stay       = 1'b1;
            state_next = (funct3 == 3'b000) ? MC_LOAD : TRAP;
          end
          OP_SYSTEM: begin
            retire     = 1'b0;
            stay       = 1'b1;
            state_next = HALT;
          end
          default: begin
            retire     = 1'b0;
            stay       = 1'b1;
            state_next = TRAP;
          end
        endcase
      end
      MC_LOAD: begin
        write_en      = 1'b1;
        alu_b_sel     = 1'b1;
        mem_read      = 1'b1;
        write_src_sel = WSRC_MEM;
        stay          = 1'b1;
        counter_sel   = 1'b1;
        state_next    = MC_STORE;
      end
      MC_STORE: begin
        alu_b_sel    = 1'b1;
        mem_write    = 1'b1;
        stay         = 1'b1;
        memcpy_store = 1'b1;
        counter_en   = 1'b1;
        counter_sel  = 1'b1;
        if (ex_no_stay) begin
          state_next = RUN;
          retire     = 1'b1;
        end else begin
          state_next = MC_LOAD;
        end
      end
      HALT, TRAP: stay = 1'b1;
      default: begin
        stay       = 1'b1;
        state_next = BOOT;
      end
    endcase
  end

  assign ctrl_word = {write_en, alu_sel, alu_b_sel, alu_a_sel, mem_write, mem_read,
                      ls_type, load_unsigned, write_src_sel, branch_type, stay,
                      memcpy_store, counter_en, counter_sel};

  assign ctrl_signals = rstn ? ctrl_word : CTRL_STAY;
  assign busy    = (state == MC_LOAD) || (state == MC_STORE);
  assign halted  = (state == HALT);
  assign illegal = (state == TRAP);

endmodule
